// File: rtl/stv_stream_upsizer.sv
// Narrow-to-wide stream packer: gathers RATIO narrow beats (or fewer, when din_last
// arrives early) into one registered wide word with a lane-valid mask.
module stv_stream_upsizer #(
    parameter int unsigned DIN_WIDTH   = 8,
    parameter int unsigned RATIO       = 4,
    localparam int unsigned DOUT_WIDTH = DIN_WIDTH * RATIO,
    localparam int unsigned IDXWIDTH   = $clog2(RATIO)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  din_last,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic [RATIO-1:0]      dout_mask,
    output logic                  dout_last,
    output logic [IDXWIDTH-1:0]   idx
);

    logic [RATIO-2:0][DIN_WIDTH-1:0] acc_q, acc_d;
    logic [RATIO-2:0]                acc_mask_q, acc_mask_d;
    logic [IDXWIDTH-1:0]             idx_q, idx_d;
    logic [DOUT_WIDTH-1:0]           dout_q, dout_d;
    logic [RATIO-1:0]                dout_mask_q, dout_mask_d;
    logic                            dout_last_q, dout_last_d;
    logic                            dout_valid_q, dout_valid_d;
    logic                            beat_accept;
    logic                            beat_close;

    // Ready depends only on registered state and dout_ready, never on din_valid/din_last.
    assign din_ready   = !dout_valid_q || dout_ready;
    assign beat_accept = din_valid && din_ready;
    assign beat_close  = din_last || (idx_q == IDXWIDTH'(RATIO - 1));

    always_comb begin
        acc_d        = acc_q;
        acc_mask_d   = acc_mask_q;
        idx_d        = idx_q;
        dout_d       = dout_q;
        dout_mask_d  = dout_mask_q;
        dout_last_d  = dout_last_q;
        dout_valid_d = dout_valid_q;

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        if (beat_accept) begin
            if (beat_close) begin
                dout_d = '0;
                for (int unsigned i = 0; i < RATIO - 1; i++) begin
                    if (acc_mask_q[i]) begin
                        dout_d[i*DIN_WIDTH +: DIN_WIDTH] = acc_q[i];
                    end
                end
                for (int unsigned i = 0; i < RATIO; i++) begin
                    if (idx_q == IDXWIDTH'(i)) begin
                        dout_d[i*DIN_WIDTH +: DIN_WIDTH] = din;
                    end
                    dout_mask_d[i] = (i <= 32'(idx_q));
                end
                dout_last_d  = din_last;
                dout_valid_d = 1'b1;
                acc_mask_d   = '0;
                idx_d        = '0;
            end else begin
                for (int unsigned i = 0; i < RATIO - 1; i++) begin
                    if (idx_q == IDXWIDTH'(i)) begin
                        acc_d[i]      = din;
                        acc_mask_d[i] = 1'b1;
                    end
                end
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_q        <= '0;
            acc_mask_q   <= '0;
            idx_q        <= '0;
            dout_q       <= '0;
            dout_mask_q  <= '0;
            dout_last_q  <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_mask_q   <= acc_mask_d;
            idx_q        <= idx_d;
            dout_q       <= dout_d;
            dout_mask_q  <= dout_mask_d;
            dout_last_q  <= dout_last_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_mask  = dout_mask_q;
    assign dout_last  = dout_last_q;
    assign dout_valid = dout_valid_q;
    assign idx        = idx_q;

`ifdef STV_ASSERT_ON
    din_stable_a: assert property (@(posedge clk) disable iff (rst || clear)
        din_valid && !din_ready |=> din_valid && $stable(din) && $stable(din_last));
    dout_stable_a: assert property (@(posedge clk) disable iff (rst || clear)
        dout_valid && !dout_ready |=> dout_valid && $stable(dout) && $stable(dout_mask)
                                      && $stable(dout_last));
    ratio_a: assert property (@(posedge clk) RATIO >= 2);
`endif

endmodule

// File: tb/tb_stv_stream_upsizer.sv
// Self-checking bench for stv_stream_upsizer: directed vector table, backpressure,
// random throughput and mid-word flush, all cross-checked by a beat-list reference model.
module tb_stv_stream_upsizer;

    localparam int unsigned DW = 8;
    localparam int unsigned RATIO = 4;

    logic        clk = 1'b0;
    logic        rst, clear;
    logic        din_valid, din_ready, din_last;
    logic [7:0]  din;
    logic        dout_valid, dout_ready, dout_last;
    logic [31:0] dout;
    logic [3:0]  dout_mask;
    logic [1:0]  idx;

    stv_stream_upsizer #(.DIN_WIDTH(DW), .RATIO(RATIO)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din        (din),
        .din_last   (din_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_mask  (dout_mask),
        .dout_last  (dout_last),
        .idx        (idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int words_seen = 0;
    int stall_cycles = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: beats of the open frame, and words owed to the consumer.
    logic [8:0]  pend[$];
    logic [36:0] expq[$];
    logic [36:0] held, e;
    logic [31:0] mw;
    logic [3:0]  mm;
    bit          stalled = 0;

    always @(negedge clk) begin
        if (rst || clear) begin
            pend.delete();
            expq.delete();
            stalled = 0;
        end else begin
            chk("din_ready", din_ready, !dout_valid || dout_ready);
            chk("idx", idx, pend.size());
            chk("dout_valid", dout_valid, expq.size() != 0);
            if (stalled) chk("stall_hold", {dout_last, dout_mask, dout}, held);
            if (dout_valid && dout_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_word", 1'b1, 1'b0);
                end else begin
                    e = expq.pop_front();
                    chk("word", {dout_last, dout_mask, dout}, e);
                end
                words_seen++;
            end
            stalled = dout_valid && !dout_ready;
            held = {dout_last, dout_mask, dout};
            if (din_valid && din_ready) begin
                pend.push_back({din_last, din});
                if (din_last || pend.size() == RATIO) begin
                    mw = 0;
                    mm = 0;
                    for (int i = 0; i < pend.size(); i++) begin
                        mw = mw | (32'(pend[i][7:0]) << (8 * i));
                        mm = mm | (4'(1) << i);
                    end
                    expq.push_back({din_last, mm, mw});
                    pend.delete();
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        din = d;
        din_last = l;
        din_valid = 1'b1;
        @(negedge clk);
        while (!din_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 1'b1, 1'b0);
        stall_cycles += n;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_last = 1'b0;
    endtask

    task automatic wait_word(output logic [31:0] w, output logic [3:0] m, output logic l);
        int n = 0;
        @(negedge clk);
        while (!dout_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("word_timeout", n < 20, 1'b1);
        w = dout;
        m = dout_mask;
        l = dout_last;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          n;
        logic [7:0]  b[4];
        logic        lst;
        logic [31:0] w;
        logic [3:0]  m;
        logic        l;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] gw;
    logic [3:0]  gm;
    logic        gl;
    int          base;

    initial begin
        vecs[0] = '{4, '{8'h11, 8'h22, 8'h33, 8'h44}, 1'b0, 32'h44332211, 4'b1111, 1'b0};
        vecs[1] = '{2, '{8'hAA, 8'hBB, 8'h00, 8'h00}, 1'b1, 32'h0000BBAA, 4'b0011, 1'b1};
        vecs[2] = '{4, '{8'h01, 8'h02, 8'h03, 8'h04}, 1'b0, 32'h04030201, 4'b1111, 1'b0};
        vecs[3] = '{1, '{8'h5C, 8'h00, 8'h00, 8'h00}, 1'b1, 32'h0000005C, 4'b0001, 1'b1};
        vecs[4] = '{4, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b1, 32'hEFBEADDE, 4'b1111, 1'b1};
        vecs[5] = '{3, '{8'hC0, 8'hC1, 8'hC2, 8'h00}, 1'b1, 32'h00C2C1C0, 4'b0111, 1'b1};

        rst = 1'b1;
        clear = 1'b0;
        din_valid = 1'b0;
        din_last = 1'b0;
        din = '0;
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_dout", dout, 32'h0);
        chk("rst_dout_mask", dout_mask, 4'h0);
        chk("rst_dout_last", dout_last, 1'b0);
        chk("rst_idx", idx, 2'd0);
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < vecs[v].n; j++) begin
                send(vecs[v].b[j], (j == vecs[v].n - 1) ? vecs[v].lst : 1'b0);
            end
            wait_word(gw, gm, gl);
            chk($sformatf("vec%0d_dout", v), gw, vecs[v].w);
            chk($sformatf("vec%0d_mask", v), gm, vecs[v].m);
            chk($sformatf("vec%0d_last", v), gl, vecs[v].l);
            chk($sformatf("vec%0d_idx0", v), idx, 2'd0);
        end

        // Backpressure: full word parked in the output register, next beat held off.
        dout_ready = 1'b0;
        send(8'hB1, 1'b0);
        send(8'hB2, 1'b0);
        send(8'hB3, 1'b0);
        send(8'hB4, 1'b0);
        din = 8'h99;
        din_last = 1'b0;
        din_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_din_ready", din_ready, 1'b0);
            chk("bp_dout", dout, 32'hB4B3B2B1);
            chk("bp_idx", idx, 2'd0);
        end
        @(posedge clk);
        #1;
        dout_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", din_ready, 1'b1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        wait_word(gw, gm, gl);
        chk("bp_resume_dout", gw, 32'hA3A2A199);
        chk("bp_resume_mask", gm, 4'b1111);

        // Throughput: 64 random beats back-to-back.
        base = words_seen;
        stall_cycles = 0;
        for (int k = 0; k < 64; k++) begin
            send(8'($urandom), 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("tput_words", words_seen - base, 16);
        chk("tput_no_stall", stall_cycles, 0);

        // Mid-word flush, first by clear then by rst.
        for (int k = 0; k < 2; k++) begin
            base = words_seen;
            send(8'h10, 1'b0);
            send(8'h20, 1'b0);
            din = 8'h30;
            din_valid = 1'b1;
            if (k == 0) clear = 1'b1;
            else rst = 1'b1;
            @(posedge clk);
            #1;
            clear = 1'b0;
            rst = 1'b0;
            din_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("flush%0d_idx", k), idx, 2'd0);
            @(posedge clk);
            #1;
            send(8'h40, 1'b0);
            send(8'h50, 1'b0);
            send(8'h60, 1'b0);
            send(8'h70, 1'b0);
            wait_word(gw, gm, gl);
            chk($sformatf("flush%0d_dout", k), gw, 32'h70605040);
            chk($sformatf("flush%0d_mask", k), gm, 4'b1111);
            chk($sformatf("flush%0d_last", k), gl, 1'b0);
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("flush%0d_words", k), words_seen - base, 1);
        end

        chk("model_drained", expq.size() + pend.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
